// File: rtl/hanoi_move_sequencer_if.sv
// Move handshake between the Hanoi sequencer and the tower datapath.
// The sequencer drives the master side; the datapath answers with mv_rdy.
interface hanoi_move_sequencer_if;
  logic       mv_vld;
  logic [1:0] mv_fr;
  logic [1:0] mv_to;
  logic       mv_rdy;

  modport master (output mv_vld, output mv_fr, output mv_to, input mv_rdy);
  modport slave  (input mv_vld, input mv_fr, input mv_to, output mv_rdy);
endinterface

// File: rtl/hanoi_move_sequencer.sv
// Tower-of-Hanoi move sequencer: generates the optimal S-disk solution or forwards
// single manual moves, checking each against a shadow copy of peg occupancy.
module hanoi_move_sequencer #(
  parameter int unsigned S = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   man_vld,
  input  logic [1:0]             man_fr,
  input  logic [1:0]             man_to,
  hanoi_move_sequencer_if.master mv,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [S-1:0]           move_cnt,
  output logic [S-1:0]           peg0,
  output logic [S-1:0]           peg1,
  output logic [S-1:0]           peg2
);

  typedef enum logic [1:0] {ST_IDLE, ST_AUTO, ST_MAN} state_t;

  localparam logic [S:0] K_ONE   = (S+1)'(1);
  localparam logic [S:0] K_THREE = (S+1)'(3);
  localparam logic [S:0] K_LAST  = (S+1)'((1 << S) - 1);

  state_t       r_state;
  logic [S-1:0] r_cnt;
  logic [S-1:0] r_peg0, r_peg1, r_peg2;
  logic [1:0]   r_fr, r_to;
  logic         r_done, r_err;

  logic [S:0]   w_m, w_and, w_orp;
  logic [1:0]   w_afr_raw, w_ato_raw, w_afr, w_ato;
  logic [1:0]   w_fr, w_to;
  logic [S-1:0] w_top, w_nxt0, w_nxt1, w_nxt2;
  logic         w_xfer, w_auto_legal, w_man_legal;

  function automatic logic [S-1:0] sel_peg(input logic [1:0] p, input logic [S-1:0] a,
                                           input logic [S-1:0] b, input logic [S-1:0] c);
    case (p)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic logic [S-1:0] top_bit(input logic [S-1:0] x);
    return x & (-x);
  endfunction

  function automatic logic [1:0] swap12(input logic [1:0] p);
    return (p == 2'd1) ? 2'd2 : ((p == 2'd2) ? 2'd1 : p);
  endfunction

  function automatic logic is_legal(input logic [1:0] fr, input logic [1:0] to,
                                    input logic [S-1:0] a, input logic [S-1:0] b,
                                    input logic [S-1:0] c);
    logic [S-1:0] st, dt;
    st = top_bit(sel_peg(fr, a, b, c));
    dt = top_bit(sel_peg(to, a, b, c));
    return (fr != to) && (fr <= 2'd2) && (to <= 2'd2) && (st != '0) &&
           ((dt == '0) || (st < dt));
  endfunction

  // Move m = cnt+1 is computed one bit wider so (m | (m-1)) + 1 cannot overflow.
  always_comb begin
    w_m       = {1'b0, r_cnt} + K_ONE;
    w_and     = w_m & (w_m - K_ONE);
    w_orp     = (w_m | (w_m - K_ONE)) + K_ONE;
    w_afr_raw = 2'(w_and % K_THREE);
    w_ato_raw = 2'(w_orp % K_THREE);
    w_afr     = (S % 2 == 0) ? swap12(w_afr_raw) : w_afr_raw;
    w_ato     = (S % 2 == 0) ? swap12(w_ato_raw) : w_ato_raw;
    w_fr      = (r_state == ST_AUTO) ? w_afr : r_fr;
    w_to      = (r_state == ST_AUTO) ? w_ato : r_to;
  end

  always_comb begin
    w_top  = top_bit(sel_peg(w_fr, r_peg0, r_peg1, r_peg2));
    w_nxt0 = r_peg0;
    w_nxt1 = r_peg1;
    w_nxt2 = r_peg2;
    if (w_fr == 2'd0) w_nxt0 = w_nxt0 & ~w_top;
    if (w_fr == 2'd1) w_nxt1 = w_nxt1 & ~w_top;
    if (w_fr == 2'd2) w_nxt2 = w_nxt2 & ~w_top;
    if (w_to == 2'd0) w_nxt0 = w_nxt0 | w_top;
    if (w_to == 2'd1) w_nxt1 = w_nxt1 | w_top;
    if (w_to == 2'd2) w_nxt2 = w_nxt2 | w_top;
  end

  assign w_xfer       = (r_state != ST_IDLE) && mv.mv_rdy;
  assign w_auto_legal = is_legal(w_afr, w_ato, r_peg0, r_peg1, r_peg2);
  assign w_man_legal  = is_legal(man_fr, man_to, r_peg0, r_peg1, r_peg2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_peg0  <= '1;
      r_peg1  <= '0;
      r_peg2  <= '0;
      r_fr    <= '0;
      r_to    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (r_peg0 == '1) begin
              r_state <= ST_AUTO;
              r_cnt   <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (man_vld) begin
            if (w_man_legal) begin
              r_state <= ST_MAN;
              r_fr    <= man_fr;
              r_to    <= man_to;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_AUTO: begin
          if (man_vld) r_err <= 1'b1;
          if (!w_auto_legal) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_peg0 <= w_nxt0;
            r_peg1 <= w_nxt1;
            r_peg2 <= w_nxt2;
            r_cnt  <= w_m[S-1:0];
            if (w_m == K_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_MAN: begin
          if (man_vld) r_err <= 1'b1;
          if (w_xfer) begin
            r_peg0  <= w_nxt0;
            r_peg1  <= w_nxt1;
            r_peg2  <= w_nxt2;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_auto_legal: assert property (@(posedge clk) disable iff (!rst)
                                 (r_state == ST_AUTO) |-> w_auto_legal);

  assign mv.mv_vld = (r_state != ST_IDLE);
  assign mv.mv_fr  = w_fr;
  assign mv.mv_to  = w_to;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign move_cnt  = r_cnt;
  assign peg0      = r_peg0;
  assign peg1      = r_peg1;
  assign peg2      = r_peg2;

endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Directed bench for hanoi_move_sequencer: manual-move vector table plus hand-written
// automatic runs for S=4 (free-running, stalled, reset mid-run) and S=3.
module tb_hanoi_move_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, man_vld4, start3, man_vld3;
  logic [1:0] man_fr4, man_to4, man_fr3, man_to3;
  logic       busy4, done4, err4, busy3, done3, err3;
  logic [3:0] cnt4, p0_4, p1_4, p2_4;
  logic [2:0] cnt3, p0_3, p1_3, p2_3;

  hanoi_move_sequencer_if mif4 ();
  hanoi_move_sequencer_if mif3 ();

  hanoi_move_sequencer #(.S(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .man_vld(man_vld4), .man_fr(man_fr4),
    .man_to(man_to4), .mv(mif4), .busy(busy4), .done(done4), .err(err4),
    .move_cnt(cnt4), .peg0(p0_4), .peg1(p1_4), .peg2(p2_4)
  );

  hanoi_move_sequencer #(.S(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .man_vld(man_vld3), .man_fr(man_fr3),
    .man_to(man_to3), .mv(mif3), .busy(busy3), .done(done3), .err(err3),
    .move_cnt(cnt3), .peg0(p0_3), .peg1(p1_3), .peg2(p2_3)
  );

  // Hand-derived optimal sequences ending on peg 2.
  logic [1:0] ef4 [15] = '{0,0,1,0,2,2,0,0,1,1,2,1,0,0,1};
  logic [1:0] et4 [15] = '{1,2,2,1,0,1,1,2,2,0,0,2,1,2,2};
  logic [1:0] ef3 [7]  = '{0,0,2,0,1,1,0};
  logic [1:0] et3 [7]  = '{2,1,1,2,0,2,2};

  typedef struct {
    logic       start;
    logic       man_vld;
    logic [1:0] man_fr;
    logic [1:0] man_to;
    logic       rdy;
    logic       e_err;
    logic       e_busy;
    logic [1:0] e_fr;
    logic [1:0] e_to;
    logic [3:0] e_p0;
    logic [3:0] e_p1;
    logic [3:0] e_p2;
  } vec_t;

  vec_t tbl [11];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_auto4(input bit inject);
    start4 = 1'b1; man_vld4 = inject; man_fr4 = 2'd0; man_to4 = 2'd2; mif4.mv_rdy = 1'b1;
    @(negedge clk);
    start4 = 1'b0; man_vld4 = 1'b0;
    chk("auto_busy", busy4, 1);
    for (int k = 0; k < 15; k++) begin
      chk("auto_vld", mif4.mv_vld, 1);
      chk("auto_fr", mif4.mv_fr, ef4[k]);
      chk("auto_to", mif4.mv_to, et4[k]);
      chk("auto_cnt", cnt4, k);
      chk("auto_err", err4, (inject && k == 4) ? 1 : 0);
      man_vld4 = inject && (k == 3);
      @(negedge clk);
    end
    man_vld4 = 1'b0;
    chk("auto_done", done4, 1);
    chk("auto_end_busy", busy4, 0);
    chk("auto_end_vld", mif4.mv_vld, 0);
    chk("auto_end_cnt", cnt4, 15);
    chk("auto_end_p0", p0_4, 0);
    chk("auto_end_p1", p1_4, 0);
    chk("auto_end_p2", p2_4, 15);
    @(negedge clk);
    chk("auto_done_pulse", done4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int k;
    int cyc;
    rst = 1'b0;
    start4 = 1'b0; man_vld4 = 1'b0; man_fr4 = '0; man_to4 = '0; mif4.mv_rdy = 1'b0;
    start3 = 1'b0; man_vld3 = 1'b0; man_fr3 = '0; man_to3 = '0; mif3.mv_rdy = 1'b0;

    //               st man fr to rdy err bsy fr to  p0    p1    p2
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[1]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 4'hF, 4'h0, 4'h0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 4'hF, 4'h0, 4'h0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 4'h0, 4'h0};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 4'hE, 4'h1, 4'h0};
    tbl[5]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 4'hE, 4'h1, 4'h0};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 4'hE, 4'h1, 4'h0};
    tbl[7]  = '{0, 1, 0, 2, 1, 0, 1, 0, 2, 4'hE, 4'h1, 4'h0};
    tbl[8]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0, 4'hC, 4'h1, 4'h2};
    tbl[9]  = '{0, 1, 1, 2, 0, 0, 1, 1, 2, 4'hC, 4'h1, 4'h2};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 4'hC, 4'h0, 4'h3};

    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", mif4.mv_vld, 0);
    chk("rst_fr", mif4.mv_fr, 0);
    chk("rst_to", mif4.mv_to, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_err", err4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_p0", p0_4, 15);
    chk("rst_p1", p1_4, 0);
    chk("rst_p2", p2_4, 0);
    chk("rst3_p0", p0_3, 7);
    chk("rst3_vld", mif3.mv_vld, 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start4 = tbl[i].start; man_vld4 = tbl[i].man_vld;
      man_fr4 = tbl[i].man_fr; man_to4 = tbl[i].man_to; mif4.mv_rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_err", i), err4, tbl[i].e_err);
      chk($sformatf("vec%0d_busy", i), busy4, tbl[i].e_busy);
      chk($sformatf("vec%0d_vld", i), mif4.mv_vld, tbl[i].e_busy);
      if (tbl[i].e_busy) begin
        chk($sformatf("vec%0d_fr", i), mif4.mv_fr, tbl[i].e_fr);
        chk($sformatf("vec%0d_to", i), mif4.mv_to, tbl[i].e_to);
      end
      chk($sformatf("vec%0d_p0", i), p0_4, tbl[i].e_p0);
      chk($sformatf("vec%0d_p1", i), p1_4, tbl[i].e_p1);
      chk($sformatf("vec%0d_p2", i), p2_4, tbl[i].e_p2);
      chk($sformatf("vec%0d_cnt", i), cnt4, 0);
      chk($sformatf("vec%0d_done", i), done4, 0);
    end
    start4 = 1'b0; man_vld4 = 1'b0; mif4.mv_rdy = 1'b0;

    // Free-running solve with start+man_vld together and a manual request mid-run.
    do_reset();
    run_auto4(1'b1);

    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("restart_err", err4, 1);
    chk("restart_busy", busy4, 0);

    // Odd disk count.
    start3 = 1'b1; mif3.mv_rdy = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      chk("s3_fr", mif3.mv_fr, ef3[j]);
      chk("s3_to", mif3.mv_to, et3[j]);
      chk("s3_cnt", cnt3, j);
      @(negedge clk);
    end
    chk("s3_done", done3, 1);
    chk("s3_busy", busy3, 0);
    chk("s3_cnt_end", cnt3, 7);
    chk("s3_p2", p2_3, 7);
    chk("s3_p0", p0_3, 0);
    chk("s3_err", err3, 0);

    // Stalled run: mv_rdy random, outputs must hold until transfer.
    do_reset();
    start4 = 1'b1; mif4.mv_rdy = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    k = 0; cyc = 0;
    while (k < 15 && cyc < 300) begin
      chk("stall_vld", mif4.mv_vld, 1);
      chk("stall_fr", mif4.mv_fr, ef4[k]);
      chk("stall_to", mif4.mv_to, et4[k]);
      chk("stall_cnt", cnt4, k);
      mif4.mv_rdy = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (mif4.mv_rdy) k++;
      @(negedge clk);
      cyc++;
    end
    mif4.mv_rdy = 1'b0;
    chk("stall_moves", k, 15);
    chk("stall_done", done4, 1);
    chk("stall_cnt_end", cnt4, 15);
    chk("stall_p2", p2_4, 15);
    chk("stall_busy", busy4, 0);

    // Asynchronous reset in the middle of a run, then a clean solve.
    do_reset();
    start4 = 1'b1; mif4.mv_rdy = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_cnt", cnt4, 5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_vld", mif4.mv_vld, 0);
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_cnt", cnt4, 0);
    chk("mid_rst_p0", p0_4, 15);
    chk("mid_rst_p1", p1_4, 0);
    chk("mid_rst_p2", p2_4, 0);
    chk("mid_rst_fr", mif4.mv_fr, 0);
    chk("mid_rst_to", mif4.mv_to, 0);
    @(negedge clk);
    rst = 1'b1;
    run_auto4(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
